// File: rtl/pc_unit.sv
// pc_unit: program-counter stage of the multi-cycle MIPS datapath.
// Holds PC and ALUOut, selects the next-PC target, traps misaligned
// targets with a sticky fault that freezes fetch, and optionally counts
// fetched instructions.
// Optional feature macro: PC_INSTR_COUNT_EN (instruction counter).
// With the macro undefined, instrCount is tied to zero.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCen,
    input  logic [1:0]  PCSrc,
    input  logic        IRWrite,
    input  logic [31:0] ALUResult,
    input  logic [25:0] instrIndex,
    input  logic [31:0] regA,
    output logic [31:0] PC,
    output logic [31:0] ALUOut,
    output logic        pcFault,
    output logic [31:0] faultAddr,
    output logic [31:0] instrCount
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IDX_W    = 26;
    localparam int unsigned REGION_W = XLEN - IDX_W - 2;

    localparam logic [1:0] SRC_ALU_RESULT = 2'b00;
    localparam logic [1:0] SRC_ALU_OUT    = 2'b01;
    localparam logic [1:0] SRC_JUMP       = 2'b10;
    localparam logic [1:0] SRC_REG_A      = 2'b11;

    logic [XLEN-1:0]     target;
    logic [XLEN-1:0]     jump_target;
    logic [REGION_W-1:0] pc_region;
    logic                misaligned;
    logic                pc_write;

    // Jump target keeps the 256 MB region of the already-incremented PC
    always_comb begin
        pc_region   = PC[XLEN-1:XLEN-REGION_W];
        jump_target = {pc_region, instrIndex, 2'b00};
    end

    // Next-PC candidate selection
    always_comb begin
        target = ALUResult;
        unique case (PCSrc)
            SRC_ALU_RESULT: target = ALUResult;
            SRC_ALU_OUT:    target = ALUOut;
            SRC_JUMP:       target = jump_target;
            SRC_REG_A:      target = regA;
            default:        target = ALUResult;
        endcase
    end

    // Alignment check and qualified PC write; a pending fault blocks all writes
    always_comb begin
        misaligned = (target[1:0] != 2'b00);
        pc_write   = PCen && !pcFault;
    end

    // PC, ALUOut and sticky fault state
    always_ff @(posedge clk) begin
        if (rst) begin
            PC        <= RESET_PC;
            ALUOut    <= '0;
            pcFault   <= 1'b0;
            faultAddr <= '0;
        end else begin
            ALUOut <= ALUResult;
            if (pc_write) begin
                if (misaligned) begin
                    pcFault   <= 1'b1;
                    faultAddr <= target;
                end else begin
                    PC <= target;
                end
            end
        end
    end

`ifdef PC_INSTR_COUNT_EN
    // Fetched-instruction counter; stops while faulted, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            instrCount <= '0;
        end else if (IRWrite && !pcFault) begin
            instrCount <= instrCount + XLEN'(1);
        end
    end
`else
    // Counter not built; IRWrite only matters to the counter
    logic unused_irwrite;
    assign unused_irwrite = IRWrite;
    assign instrCount     = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit with a reference model and an
// expected-result queue checked one cycle after each driven step.
module tb_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic        fault;
        logic [31:0] fault_addr;
        logic [31:0] count;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCen;
    logic [1:0]  PCSrc;
    logic        IRWrite;
    logic [31:0] ALUResult;
    logic [25:0] instrIndex;
    logic [31:0] regA;
    logic [31:0] PC;
    logic [31:0] ALUOut;
    logic        pcFault;
    logic [31:0] faultAddr;
    logic [31:0] instrCount;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    // model state
    logic [31:0] m_pc, m_alu_out, m_fault_addr, m_count;
    logic        m_fault;

    pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .PCen(PCen), .PCSrc(PCSrc), .IRWrite(IRWrite),
        .ALUResult(ALUResult), .instrIndex(instrIndex), .regA(regA),
        .PC(PC), .ALUOut(ALUOut), .pcFault(pcFault), .faultAddr(faultAddr),
        .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, push expectation,
    // then after the edge pop and compare against the DUT.
    task automatic step(input string tag, input logic r, input logic en,
                        input logic [1:0] src, input logic irw,
                        input logic [31:0] alu, input logic [25:0] idx,
                        input logic [31:0] ra);
        logic [31:0] tgt;
        exp_t e;
        exp_t got;
        rst = r; PCen = en; PCSrc = src; IRWrite = irw;
        ALUResult = alu; instrIndex = idx; regA = ra;
        case (src)
            2'b00:   tgt = alu;
            2'b01:   tgt = m_alu_out;
            2'b10:   tgt = {m_pc[31:28], idx, 2'b00};
            default: tgt = ra;
        endcase
        if (r) begin
            m_pc = RST_PC; m_alu_out = 32'h0; m_fault = 1'b0;
            m_fault_addr = 32'h0; m_count = 32'h0;
        end else begin
`ifdef PC_INSTR_COUNT_EN
            if (irw && !m_fault) m_count = m_count + 32'd1;
`endif
            if (en && !m_fault) begin
                if (tgt[1:0] != 2'b00) begin
                    m_fault = 1'b1;
                    m_fault_addr = tgt;
                end else begin
                    m_pc = tgt;
                end
            end
            m_alu_out = alu;
        end
        e.tag = tag; e.pc = m_pc; e.alu_out = m_alu_out; e.fault = m_fault;
        e.fault_addr = m_fault_addr; e.count = m_count;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({got.tag, ".pc"},         PC,                 got.pc);
        chk({got.tag, ".aluout"},     ALUOut,             got.alu_out);
        chk({got.tag, ".fault"},      {31'h0, pcFault},   {31'h0, got.fault});
        chk({got.tag, ".faultaddr"},  faultAddr,          got.fault_addr);
        chk({got.tag, ".count"},      instrCount,         got.count);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_cnt3;
        m_pc = RST_PC; m_alu_out = '0; m_fault = 1'b0; m_fault_addr = '0; m_count = '0;
        rst = 1'b1; PCen = 1'b0; PCSrc = 2'b00; IRWrite = 1'b0;
        ALUResult = '0; instrIndex = '0; regA = '0;
        @(negedge clk);

        step("reset0", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
        step("reset1", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
        chk("reset_pc", PC, 32'h0000_0040);

        // three sequential fetches
        step("fetch1", 1'b0, 1'b1, 2'b00, 1'b1, 32'h44, 26'h0, 32'h0);
        step("fetch2", 1'b0, 1'b1, 2'b00, 1'b1, 32'h48, 26'h0, 32'h0);
        step("fetch3", 1'b0, 1'b1, 2'b00, 1'b1, 32'h4C, 26'h0, 32'h0);
        chk("fetch_pc", PC, 32'h0000_004C);
`ifdef PC_INSTR_COUNT_EN
        exp_cnt3 = 32'd3;
`else
        exp_cnt3 = 32'd0;
`endif
        chk("fetch_count", instrCount, exp_cnt3);

        // branch: target computed in decode, taken from ALUOut
        step("decode", 1'b0, 1'b0, 2'b00, 1'b0, 32'h100, 26'h0, 32'h0);
        chk("decode_aluout", ALUOut, 32'h0000_0100);
        step("branch", 1'b0, 1'b1, 2'b01, 1'b0, 32'hDEAD, 26'h0, 32'h0);
        chk("branch_pc", PC, 32'h0000_0100);

        // jump within region of PC
        step("to_4000", 1'b0, 1'b1, 2'b00, 1'b1, 32'h4000_0008, 26'h0, 32'h0);
        step("jump", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 26'h000_0010, 32'h0);
        chk("jump_pc", PC, 32'h4000_0040);

        // JR misaligned: fault, PC frozen
        step("jr_fault", 1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 26'h0, 32'h0000_0102);
        chk("jr_fault_flag", {31'h0, pcFault}, 32'h1);
        chk("jr_fault_addr", faultAddr, 32'h0000_0102);
        chk("jr_fault_pc", PC, 32'h4000_0040);
        step("jr_again", 1'b0, 1'b1, 2'b11, 1'b1, 32'h0, 26'h0, 32'h0000_0203);
        step("aligned_frozen", 1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0200, 26'h0, 32'h0);
        chk("frozen_addr", faultAddr, 32'h0000_0102);
        chk("frozen_pc", PC, 32'h4000_0040);
        chk("frozen_aluout", ALUOut, 32'h0000_0200);

        // reset wins over a same-edge PC write
        step("rst_vs_pcen", 1'b1, 1'b1, 2'b00, 1'b1, 32'h80, 26'h0, 32'h0);
        chk("rst_pc", PC, 32'h0000_0040);
        chk("rst_fault", {31'h0, pcFault}, 32'h0);

        // random aligned/misaligned traffic against the model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, ra;
            a  = $urandom;
            ra = $urandom;
            if ((i % 8) != 7) begin
                a[1:0]  = 2'b00;
                ra[1:0] = 2'b00;
            end
            step("rand", 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), a, 26'($urandom), ra);
            if (i == 20)
                step("rand_rst", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
